// File: rtl/exc_arbiter_pkg.sv
// Shared constants for the MEM-stage exception arbiter: exception codes,
// stall bus layout, FSM states and the BadVAddr source selector.
package exc_arbiter_pkg;
    localparam int EXC_CODE_W = 5;
    localparam int STALL_W    = 6;
    localparam int STALL_MEM  = 4;
    localparam logic STOP     = 1'b1;
    localparam logic NOSTOP   = 1'b0;

    typedef logic [EXC_CODE_W-1:0] exc_code_t;

    localparam exc_code_t EXC_INT  = 5'h00;
    localparam exc_code_t EXC_ADEL = 5'h04;
    localparam exc_code_t EXC_ADES = 5'h05;
    localparam exc_code_t EXC_SYS  = 5'h08;
    localparam exc_code_t EXC_BP   = 5'h09;
    localparam exc_code_t EXC_RI   = 5'h0a;
    localparam exc_code_t EXC_OV   = 5'h0c;
    localparam exc_code_t EXC_NONE = 5'h10;
    localparam exc_code_t EXC_ERET = 5'h11;

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_SQUASH} state_t;
    typedef enum logic [1:0] {DSEL_ZERO, DSEL_PC, DSEL_DATA} dsel_t;

    // Enabled, unmasked interrupt with IE set and EXL clear.
    function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
        return (|(cause[15:8] & status[15:8])) & status[0] & ~status[1];
    endfunction
endpackage

// File: rtl/exc_prio.sv
// Fixed-priority exception encoder: picks one code from the MEM-stage flags
// and the registered interrupt, plus where BadVAddr should come from.
module exc_prio
    import exc_arbiter_pkg::*;
(
    input  logic      int_q,
    input  logic      adel_if,
    input  logic      ri,
    input  logic      sys,
    input  logic      bp,
    input  logic      ov,
    input  logic      adel,
    input  logic      ades,
    input  logic      eret,
    output exc_code_t code,
    output dsel_t     dsel
);
    always_comb begin
        code = EXC_NONE;
        dsel = DSEL_ZERO;
        if (int_q) begin
            code = EXC_INT;
        end else if (adel_if) begin
            code = EXC_ADEL;
            dsel = DSEL_PC;
        end else if (ri) begin
            code = EXC_RI;
        end else if (sys) begin
            code = EXC_SYS;
        end else if (bp) begin
            code = EXC_BP;
        end else if (ov) begin
            code = EXC_OV;
        end else if (adel) begin
            code = EXC_ADEL;
            dsel = DSEL_DATA;
        end else if (ades) begin
            code = EXC_ADES;
            dsel = DSEL_DATA;
        end else if (eret) begin
            code = EXC_ERET;
        end
    end
endmodule

// File: rtl/exc_arbiter.sv
// MEM-stage exception arbiter: emits one exception code to CP0 for exactly one
// unstalled cycle, holds it across MEM stalls, then squashes while flush drains.
module exc_arbiter
    import exc_arbiter_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int SQUASH_CYC = 1
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  valid_i,
    input  logic [PC_W-1:0]       pc_i,
    input  logic                  is_branch_i,
    input  logic                  exc_adel_if_i,
    input  logic                  exc_ri_i,
    input  logic                  exc_sys_i,
    input  logic                  exc_bp_i,
    input  logic                  exc_ov_i,
    input  logic                  exc_adel_i,
    input  logic                  exc_ades_i,
    input  logic                  eret_i,
    input  logic [31:0]           daddr_i,
    input  logic [31:0]           status_i,
    input  logic [31:0]           cause_i,
    output logic [EXC_CODE_W-1:0] exccode_o,
    output logic [PC_W-1:0]       pc_o,
    output logic                  in_delay_o,
    output logic [31:0]           daddr_o
);
    localparam int CNT_W = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC) : 1;

    state_t          state;
    logic [CNT_W-1:0] sq_cnt;
    logic            int_q;
    logic            dly_q;
    exc_code_t       held_code;
    logic [PC_W-1:0] held_pc;
    logic [31:0]     held_daddr;
    logic            held_dly;

    exc_code_t   prio_code;
    dsel_t       prio_dsel;
    exc_code_t   cand_code;
    logic [31:0] cand_daddr;
    logic        stop;
    logic        emit;
    logic        unused_bits;

    assign unused_bits = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_MEM-1:0],
                           status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
    assign stop = (stall[STALL_MEM] == STOP);

    exc_prio u_prio (
        .int_q   (int_q),
        .adel_if (exc_adel_if_i),
        .ri      (exc_ri_i),
        .sys     (exc_sys_i),
        .bp      (exc_bp_i),
        .ov      (exc_ov_i),
        .adel    (exc_adel_i),
        .ades    (exc_ades_i),
        .eret    (eret_i),
        .code    (prio_code),
        .dsel    (prio_dsel)
    );

    // Only a real instruction in RUN can raise a new exception.
    always_comb begin
        cand_code  = (valid_i && state == ST_RUN) ? prio_code : EXC_NONE;
        cand_daddr = '0;
        case (prio_dsel)
            DSEL_PC:   cand_daddr = 32'(pc_i);
            DSEL_DATA: cand_daddr = daddr_i;
            default:   cand_daddr = '0;
        endcase
    end

    always_comb begin
        exccode_o  = EXC_NONE;
        pc_o       = '0;
        in_delay_o = 1'b0;
        daddr_o    = '0;
        emit       = 1'b0;
        if (cpu_rst_n) begin
            case (state)
                ST_RUN: begin
                    if (cand_code != EXC_NONE && !stop) begin
                        emit       = 1'b1;
                        exccode_o  = cand_code;
                        pc_o       = pc_i;
                        in_delay_o = dly_q;
                        daddr_o    = cand_daddr;
                    end
                end
                ST_HOLD: begin
                    if (!stop) begin
                        emit       = 1'b1;
                        exccode_o  = held_code;
                        pc_o       = held_pc;
                        in_delay_o = held_dly;
                        daddr_o    = held_daddr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state      <= ST_RUN;
            sq_cnt     <= '0;
            int_q      <= 1'b0;
            dly_q      <= 1'b0;
            held_code  <= EXC_NONE;
            held_pc    <= '0;
            held_daddr <= '0;
            held_dly   <= 1'b0;
        end else begin
            int_q <= int_pending(status_i, cause_i);
            if (emit) begin
                dly_q <= 1'b0;
            end else if (state == ST_RUN && valid_i && !stop) begin
                dly_q <= is_branch_i;
            end
            case (state)
                ST_RUN: begin
                    if (cand_code != EXC_NONE) begin
                        if (stop) begin
                            state      <= ST_HOLD;
                            held_code  <= cand_code;
                            held_pc    <= pc_i;
                            held_daddr <= cand_daddr;
                            held_dly   <= dly_q;
                        end else begin
                            state  <= ST_SQUASH;
                            sq_cnt <= CNT_W'(SQUASH_CYC - 1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stop) begin
                        state  <= ST_SQUASH;
                        sq_cnt <= CNT_W'(SQUASH_CYC - 1);
                    end
                end
                ST_SQUASH: begin
                    if (sq_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        sq_cnt <= sq_cnt - 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_arbiter.sv
// Bench for exc_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of the exception arbitration rules.
module tb_exc_arbiter;
    localparam int SQ = 1;
    localparam logic [4:0] NONE = 5'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        valid, is_branch, adel_if, ri, sys, bp, ov, adel, ades, eret;
    logic [31:0] pc, daddr, status, cause;
    logic [4:0]  exccode_o;
    logic [31:0] pc_o, daddr_o;
    logic        in_delay_o;

    int total = 0;
    int bad   = 0;

    // Model state: registered interrupt, delay-slot bit, a parked exception
    // waiting for the stall to clear, and remaining squash cycles.
    bit          m_int, m_dly, m_held, h_dly;
    logic [4:0]  h_code;
    logic [31:0] h_pc, h_daddr;
    int          m_sq;

    always #5 clk = ~clk;

    exc_arbiter #(.PC_W(32), .SQUASH_CYC(SQ)) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst_n),
        .stall         (stall),
        .valid_i       (valid),
        .pc_i          (pc),
        .is_branch_i   (is_branch),
        .exc_adel_if_i (adel_if),
        .exc_ri_i      (ri),
        .exc_sys_i     (sys),
        .exc_bp_i      (bp),
        .exc_ov_i      (ov),
        .exc_adel_i    (adel),
        .exc_ades_i    (ades),
        .eret_i        (eret),
        .daddr_i       (daddr),
        .status_i      (status),
        .cause_i       (cause),
        .exccode_o     (exccode_o),
        .pc_o          (pc_o),
        .in_delay_o    (in_delay_o),
        .daddr_o       (daddr_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; stall = '0; valid = 1'b0; is_branch = 1'b0;
        adel_if = 1'b0; ri = 1'b0; sys = 1'b0; bp = 1'b0; ov = 1'b0;
        adel = 1'b0; ades = 1'b0; eret = 1'b0;
        pc = '0; daddr = '0;
    endtask

    // Checks the current cycle against the model, advances the model, and
    // returns at the next falling edge with inputs still held.
    task automatic cycle();
        logic [4:0]  codes [9];
        bit          flags [9];
        int          srcs  [9];
        logic [4:0]  e_code, c_code;
        logic [31:0] e_pc, e_daddr, c_daddr;
        bit          e_dly, emitted, stop, running;
        codes = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05, 5'h11};
        srcs  = '{0, 1, 0, 0, 0, 0, 2, 2, 0};
        flags = '{m_int, adel_if, ri, sys, bp, ov, adel, ades, eret};
        #1;
        e_code = NONE; e_pc = '0; e_daddr = '0; e_dly = 1'b0; emitted = 1'b0;
        stop = stall[4];
        if (!rst_n) begin
            m_int = 0; m_dly = 0; m_held = 0; m_sq = 0;
        end else begin
            running = !m_held && (m_sq == 0);
            c_code = NONE; c_daddr = '0;
            if (running && valid) begin
                for (int i = 0; i < 9; i++) begin
                    if (flags[i] && c_code == NONE) begin
                        c_code  = codes[i];
                        c_daddr = (srcs[i] == 1) ? pc : (srcs[i] == 2) ? daddr : 32'h0;
                    end
                end
            end
            if (m_held) begin
                if (!stop) begin
                    e_code = h_code; e_pc = h_pc; e_daddr = h_daddr; e_dly = h_dly;
                    emitted = 1; m_held = 0; m_sq = SQ;
                end
            end else if (m_sq > 0) begin
                m_sq--;
            end else if (c_code != NONE) begin
                if (stop) begin
                    m_held = 1; h_code = c_code; h_pc = pc; h_daddr = c_daddr; h_dly = m_dly;
                end else begin
                    e_code = c_code; e_pc = pc; e_daddr = c_daddr; e_dly = m_dly;
                    emitted = 1; m_sq = SQ;
                end
            end
            if (emitted) m_dly = 0;
            else if (running && valid && !stop) m_dly = is_branch;
            m_int = (|(cause[15:8] & status[15:8])) && status[0] && !status[1];
        end
        chk("code", 32'(exccode_o), 32'(e_code));
        chk("pc", pc_o, e_pc);
        chk("in_delay", 32'(in_delay_o), 32'(e_dly));
        chk("daddr", daddr_o, e_daddr);
        @(negedge clk);
    endtask

    initial begin
        idle();
        status = '0; cause = '0;
        rst_n = 1'b0;
        @(negedge clk);
        #1 chk("rst_code", 32'(exccode_o), 32'h10);
        chk("rst_pc", pc_o, 32'h0);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // Unstalled RI: same-cycle emit, squash next cycle.
        valid = 1; pc = 32'h8000_0100; ri = 1;
        #1 chk("ri_code", 32'(exccode_o), 32'h0a);
        chk("ri_pc", pc_o, 32'h8000_0100);
        cycle();
        idle();
        #1 chk("ri_squash", 32'(exccode_o), 32'h10);
        cycle();

        // Branch then OV in its delay slot.
        valid = 1; pc = 32'h8000_0200; is_branch = 1;
        cycle();
        is_branch = 0; pc = 32'h8000_0204; ov = 1;
        #1 chk("ov_code", 32'(exccode_o), 32'h0c);
        chk("ov_dly", 32'(in_delay_o), 32'h1);
        cycle();
        idle(); cycle();

        // Data ADES held across a 3-cycle stall.
        valid = 1; pc = 32'h8000_0300; ades = 1; daddr = 32'h0000_1003; stall = 6'h10;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ades_stalled", 32'(exccode_o), 32'h10);
            cycle();
        end
        stall = 6'h00; ri = 1;
        #1 chk("ades_code", 32'(exccode_o), 32'h05);
        chk("ades_daddr", daddr_o, 32'h0000_1003);
        cycle();
        #1 chk("ades_once", 32'(exccode_o), 32'h10);
        cycle();
        idle(); cycle();

        // Interrupt with one cycle of latency, then masked by EXL.
        status = 32'h0000_0401; cause = 32'h0000_0400;
        cycle();
        valid = 1; pc = 32'h8000_0400;
        #1 chk("int_code", 32'(exccode_o), 32'h00);
        cycle();
        cycle();
        #1 chk("int_again", 32'(exccode_o), 32'h00);
        cycle();
        valid = 0; status = 32'h0000_0403;
        cycle(); cycle();
        valid = 1;
        #1 chk("int_exl", 32'(exccode_o), 32'h10);
        cycle();
        status = '0; cause = '0; idle(); cycle();

        // RI beats SYS; back-to-back SYS suppressed in the squash cycle.
        valid = 1; pc = 32'h8000_0500; ri = 1; sys = 1;
        #1 chk("ri_sys", 32'(exccode_o), 32'h0a);
        cycle();
        ri = 0; pc = 32'h8000_0504;
        #1 chk("sys_squash", 32'(exccode_o), 32'h10);
        cycle();
        #1 chk("sys_code", 32'(exccode_o), 32'h08);
        cycle();
        idle(); cycle();

        // Reset while holding discards the parked exception.
        valid = 1; pc = 32'h8000_0600; sys = 1; stall = 6'h10;
        cycle();
        rst_n = 0;
        #1 chk("hold_rst", 32'(exccode_o), 32'h10);
        cycle();
        idle();
        #1 chk("post_rst", 32'(exccode_o), 32'h10);
        chk("post_rst_pc", pc_o, 32'h0);
        cycle(); cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            stall     = ($urandom_range(0, 3) == 0) ? 6'h10 : 6'h00;
            stall     = stall | 6'($urandom_range(0, 3));
            valid     = ($urandom_range(0, 3) != 0);
            pc        = $urandom & 32'hffff_fffc;
            daddr     = $urandom;
            is_branch = ($urandom_range(0, 3) == 0);
            adel_if   = ($urandom_range(0, 15) == 0);
            ri        = ($urandom_range(0, 15) == 0);
            sys       = ($urandom_range(0, 15) == 0);
            bp        = ($urandom_range(0, 15) == 0);
            ov        = ($urandom_range(0, 15) == 0);
            adel      = ($urandom_range(0, 15) == 0);
            ades      = ($urandom_range(0, 15) == 0);
            eret      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) status = $urandom & 32'h0000_ff03;
            if ($urandom_range(0, 7) == 0)
                cause = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h0000_ff00) : 32'h0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
